// File: rtl/mux_result_fifo.sv
// First-word-fall-through result FIFO behind the operand mux.
// It also keeps a running checksum and a count of every word it accepts.
module mux_result_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     count,
  output logic [WIDTH-1:0]           sum,
  output logic [31:0]                total
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push;
  logic             pop;

  // The handshake flags depend only on occupancy, so no input reaches them combinationally.
  assign in_ready  = (count != FULL_COUNT);
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign out_data = out_valid ? mem[rd_ptr] : '0;

  // Storage is left uncleared on reset; the masked out_data hides stale entries.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

  // Checksum and word count track accepted words only; pops leave them alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum   <= '0;
      total <= '0;
    end else if (push) begin
      sum   <= sum + in_data;
      total <= total + 32'd1;
    end
  end

endmodule

// File: tb/tb_mux_result_fifo.sv
// Directed and randomized checks of mux_result_fifo against a queue-based model.
module tb_mux_result_fifo;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [2:0]       count;
  logic [WIDTH-1:0] sum;
  logic [31:0]      total;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] model_q[$];
  logic [31:0] model_sum;
  logic [31:0] model_total;
  logic        last_push;
  logic        last_pop;
  logic [31:0] last_popped;

  always #5 clk = ~clk;

  mux_result_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .count(count),
    .sum(sum),
    .total(total)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs, let the model react at the edge, then settle.
  task automatic applyStimulus(input logic r, input logic v, input logic [31:0] d, input logic ordy);
    logic do_push;
    logic do_pop;
    rst = r;
    in_valid = v;
    in_data = d;
    out_ready = ordy;
    @(posedge clk);
    last_push = 1'b0;
    last_pop = 1'b0;
    if (r) begin
      model_q.delete();
      model_sum = '0;
      model_total = '0;
    end else begin
      do_push = v && (model_q.size() < DEPTH);
      do_pop = ordy && (model_q.size() > 0);
      if (do_pop) begin
        last_popped = model_q.pop_front();
        last_pop = 1'b1;
      end
      if (do_push) begin
        model_q.push_back(d);
        model_sum = model_sum + d;
        model_total = model_total + 32'd1;
        last_push = 1'b1;
      end
    end
    #1;
  endtask

  task automatic checkOutput(input string tag);
    logic [31:0] exp_data;
    exp_data = (model_q.size() > 0) ? model_q[0] : 32'd0;
    check({tag, ".count"}, 32'(count), 32'(model_q.size()));
    check({tag, ".in_ready"}, 32'(in_ready), 32'(model_q.size() < DEPTH));
    check({tag, ".out_valid"}, 32'(out_valid), 32'(model_q.size() > 0));
    check({tag, ".out_data"}, out_data, exp_data);
    check({tag, ".sum"}, sum, model_sum);
    check({tag, ".total"}, total, model_total);
  endtask

  initial begin
    logic [31:0] word;
    logic [31:0] next_expected;
    int emerged;
    int sent;
    logic ordy;

    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;
    model_q.delete();
    model_sum = '0;
    model_total = '0;
    last_popped = '0;

    // Reset held two cycles with a push presented.
    applyStimulus(1'b1, 1'b1, 32'd55, 1'b1);
    checkOutput("reset0");
    applyStimulus(1'b1, 1'b1, 32'd55, 1'b1);
    checkOutput("reset1");
    check("reset.out_data_zero", out_data, 32'd0);

    // Single word in and out.
    applyStimulus(1'b0, 1'b1, 32'd777, 1'b0);
    checkOutput("single_push");
    check("single.out_data", out_data, 32'd777);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
    checkOutput("single_pop");

    // Fill, then hold a fifth word while full.
    applyStimulus(1'b0, 1'b1, 32'd999, 1'b0);
    applyStimulus(1'b0, 1'b1, 32'd1, 1'b0);
    applyStimulus(1'b0, 1'b1, 32'd2, 1'b0);
    applyStimulus(1'b0, 1'b1, 32'd3, 1'b0);
    checkOutput("fill4");
    check("fill.in_ready_low", 32'(in_ready), 32'd0);
    applyStimulus(1'b0, 1'b1, 32'd4, 1'b0);
    checkOutput("fill_held");
    check("fill.total_held", total, 32'd5);
    applyStimulus(1'b0, 1'b1, 32'd4, 1'b1);
    check("fill.popped_999", last_popped, 32'd999);
    checkOutput("fill_pop");
    applyStimulus(1'b0, 1'b1, 32'd4, 1'b0);
    check("fill.accept4", 32'(last_push), 32'd1);
    checkOutput("fill_accept");

    // Bring occupancy down to two, then push and pop together.
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
    applyStimulus(1'b0, 1'b0, 32'd0, 1'b1);
    checkOutput("at_two");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 1'b1, $urandom, 1'b1);
      checkOutput($sformatf("pushpop%0d", i));
    end
    check("pushpop.count2", 32'(count), 32'd2);

    // Stream 0..9 after a fresh reset with a random consumer.
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0);
    sent = 0;
    emerged = 0;
    next_expected = 0;
    for (int cyc = 0; cyc < 200 && emerged < 10; cyc++) begin
      ordy = 1'($urandom_range(0, 1));
      word = 32'(sent);
      applyStimulus(1'b0, sent < 10, word, ordy);
      if (last_push) sent++;
      if (last_pop) begin
        check("wrap.order", last_popped, next_expected);
        next_expected++;
        emerged++;
      end
      checkOutput("wrap");
    end
    check("wrap.emerged", 32'(emerged), 32'd10);
    check("wrap.total10", total, 32'd10);

    // Checksum wraps modulo 2^32.
    applyStimulus(1'b1, 1'b0, 32'd0, 1'b0);
    applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0);
    applyStimulus(1'b0, 1'b1, 32'd2, 1'b0);
    checkOutput("csum");
    check("csum.sum1", sum, 32'd1);

    // Reset with two words buffered discards them.
    applyStimulus(1'b1, 1'b1, 32'd9, 1'b1);
    checkOutput("midreset");
    check("midreset.count0", 32'(count), 32'd0);
    check("midreset.out_valid0", 32'(out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mux_result_fifo.md
# mux_result_fifo

Buffers the 32-bit result word `z` produced by the operand mux stage and hands it downstream over a valid/ready handshake. It also keeps a wrapping checksum and a count of every accepted word for end-of-run result reporting. It sits directly after the mux and decouples mux output timing from the consumer. First-word-fall-through FIFO with a fixed depth and no input-to-output bypass.

## Interface

Parameters:
- `WIDTH`, 32, data width of `in_data`, `out_data`, `sum`
- `DEPTH`, 4, number of entries; must be a power of two, ≥ 2

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  reset; synchronous and active-high
- `in_data`  in  WIDTH  word from the mux output `z`
- `in_valid`  in  1  `in_data` is valid this cycle
- `in_ready`  out  1  FIFO can accept a word this cycle
- `out_data`  out  WIDTH  head-of-FIFO word
- `out_valid`  out  1  `out_data` is valid
- `out_ready`  in  1  consumer takes the head word this cycle
- `count`  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- `sum`  out  WIDTH  wrapping sum of all accepted words
- `total`  out  32  number of accepted words, wrapping

## Operation

- push = `in_valid && in_ready`; pop = `out_valid && out_ready`.
- `in_ready` = (`count` != DEPTH); it is a function of occupancy only and must not depend on `out_ready`.
- `out_valid` = (`count` != 0).
- `out_data` = mem[rd_ptr] when `out_valid`; it is forced to 0 when empty.
- Storage: DEPTH-entry array, write pointer and read pointer of $clog2(DEPTH) bits each, wrapping naturally modulo DEPTH.
- On push: mem[wr_ptr] <= `in_data`; wr_ptr increments; `sum` <= `sum` + `in_data` (mod 2^WIDTH); `total` increments (mod 2^32).
- On pop: rd_ptr increments.
- Count update: push only → +1; pop only → −1; push and pop together → unchanged, both pointers advance.
- Full: push cannot occur because `in_ready` is low. The word on `in_data` is held by the producer, not dropped. A pop in that same cycle frees a slot; `in_ready` rises the next cycle.
- Empty: no pop possible. A push when empty appears at the output the next cycle, never in the same cycle.
- `sum` and `total` count pushes only. Pops do not affect them.
- Reset:
  - `count`, both pointers, `sum` and `total` are 0.
  - Outputs are `in_ready`=1, `out_valid`=0, `out_data`=0.
  - Memory contents are not cleared but are unobservable because `out_data` is masked.
- Reset mid-operation discards all buffered words. Any push or pop presented in the reset cycle is ignored.

## Timing

- Input-to-output latency: a word pushed at edge N is on `out_data` with `out_valid`=1 from just after edge N, and can be popped at edge N+1 at the earliest.
- Throughput: one push and one pop per cycle sustained when 0 < `count` < DEPTH.
- `in_ready`, `out_valid`, `count`, `sum` and `total` are all registered-state functions, with no combinational path from `in_valid`/`out_ready`.
- `out_data` is a combinational read of registered memory at the registered rd_ptr.
- Producer rule: once `in_valid` is asserted, it and `in_data` hold until `in_ready` is sampled high.

## Test plan

- **Reset:**
  - Stimulus: assert `rst` for 2 cycles with `in_valid`=1.
  - Required: `count`=0, `sum`=0, `total`=0, `in_ready`=1, `out_valid`=0, `out_data`=0.
- **Single word:**
  - Stimulus: push 777 with `out_ready`=0.
  - Required: next cycle `out_valid`=1, `out_data`=777, `count`=1, `sum`=777, `total`=1.
  - Then: pop → `count`=0, `out_data`=0.
- **Fill:**
  - Stimulus: push 999, 1, 2, 3 with `out_ready`=0.
  - Required: `count`=4, `in_ready`=0, and 5th word 4 held on `in_data` is not accepted.
  - Then: pop once → 999 leaves; `in_ready`=1 next cycle; 4 is accepted the cycle after that.
- **Simultaneous push/pop:**
  - Stimulus: at `count`=2, push and pop every cycle for 8 cycles.
  - Required: `count` stays 2 and output order equals input order.
- **Wrap-around:**
  - Stimulus: stream 0..9 with random `out_ready`.
  - Required: all 10 words emerge in order and `total`=10 at the end.
- **Checksum wrap:**
  - Stimulus: push 0xFFFFFFFF then 2.
  - Required: `sum`=1.
  - Then: assert `rst` with 2 words buffered → `count`=0, `out_valid`=0 next cycle.
